firebird_multicycle_ctrl: RTL and testbench
===========================================

# firebird_multicycle_ctrl

Main control FSM for the multi-cycle Firebird RV32I core. It sequences instruction fetch, decode, execute, memory access and write-back over a shared datapath: PC, IR, register file, immediate generator, ALU and data memory port. It drives the immediate-format select, ALU operand and operation selects, and register/PC write enables, and it handshakes with the instruction and data memories. Illegal opcodes and memory timeouts are trapped.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of cycles a memory request may stay unacknowledged before a trap; 0 disables the timeout.

Ports (clock and reset first; reset is synchronous and active-low):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- inst, in, 32: IR contents (instruction being executed).
- alu_zero, in, 1: ALU result == 0.
- alu_lt, in, 1: signed rs1 < rs2.
- alu_ltu, in, 1: unsigned rs1 < rs2.
- imem_req, out, 1: instruction fetch request.
- imem_ready, in, 1: fetch data valid; transfer occurs when req && ready.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: data access is a store.
- dmem_ready, in, 1: data access complete; transfer occurs when req && ready.
- ir_we, out, 1: load IR from fetch data.
- pc_we, out, 1: update PC.
- pc_sel, out, 1: 0 = PC+4, 1 = PC+imm.
- imm_sel, out, 2: 00 = I, 01 = S, 10 = B, 11 = unused.
- alu_src_b, out, 1: 0 = rs2, 1 = imm.
- alu_op, out, 2: 00 = add, 01 = sub/compare, 10 = decode funct3/funct7.
- reg_we, out, 1: register file write.
- wb_sel, out, 1: 0 = ALU result, 1 = memory data.
- trap, out, 1: sticky fault flag.
- state_dbg, out, 3: current state encoding.

## Operation
- **States and encodings:** IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
- **Registered and combinational outputs:** Only the state and the timeout counter are registered. All other outputs are combinational from the state, inst and the handshake inputs.
- **Reset:** rst_n low at a clock edge forces IDLE, clears the counter and clears trap. This holds mid-operation too; any outstanding request is abandoned.
- **IDLE:** all outputs are 0. The FSM goes to FETCH on the next cycle.
- **FETCH:**
  - imem_req = 1.
  - When imem_ready is high, ir_we = 1 in the same cycle and the FSM goes to DECODE.
  - Otherwise the FSM stays in FETCH.
- **DECODE:** classifies inst[6:0].
  - 0110011 = R, 0010011 = I-ALU, 0000011 = LOAD, 0100011 = STORE, 1100011 = BRANCH.
  - Any other opcode goes to TRAP.
  - All valid opcodes go to EXEC.
- **imm_sel:** derived from opcode class in every state after FETCH.
  - I-ALU and LOAD use I.
  - STORE uses S.
  - BRANCH uses B.
  - R uses I (value is don't-care).
- **EXEC:**
  - R: alu_src_b = 0, alu_op = 10, then go to WB.
  - I-ALU: alu_src_b = 1, alu_op = 10, then go to WB.
  - LOAD/STORE: alu_src_b = 1, alu_op = 00 (address), then go to MEM.
  - BRANCH: alu_src_b = 0, alu_op = 01; pc_we = 1; pc_sel = taken; then go to FETCH.
- **Branch taken, by funct3:**
  - 000: alu_zero
  - 001: !alu_zero
  - 100: alu_lt
  - 101: !alu_lt
  - 110: alu_ltu
  - 111: !alu_ltu
  - 010/011: illegal, go to TRAP instead. No pc_we in this case.
- **MEM:**
  - dmem_req = 1; dmem_we = 1 for STORE. alu_src_b and alu_op are held at their EXEC values.
  - On dmem_ready: LOAD goes to WB; STORE asserts pc_we = 1 with pc_sel = 0 and goes to FETCH.
- **WB:**
  - reg_we = 1; wb_sel = 1 for LOAD, else 0.
  - pc_we = 1, pc_sel = 0; then go to FETCH.
- **TRAP:**
  - trap = 1.
  - All other outputs are 0.
  - The FSM stays in TRAP until reset.
- **Timeout counter:**
  - Increments each cycle in FETCH or MEM while ready is low.
  - Clears on a transfer and on any other state.
  - If TIMEOUT != 0 and the counter == TIMEOUT-1 with ready still low, the FSM goes to TRAP next.
  - A ready that arrives in the same cycle as the timeout condition wins: the transfer happens.
  - The counter width is clog2(TIMEOUT+1), minimum 1.
- **Unused outputs:** any output not listed for a state is 0.

## Timing
- **Cycles per instruction with zero-wait memory:**
  - R and I-ALU: 4 (F, D, E, WB).
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- **Wait states:** each memory wait cycle adds 1 cycle.
- **Handshake:** a request stays asserted from state entry until the transfer cycle. It deasserts the cycle after.
- **Write enables:** pc_we, ir_we and reg_we are single-cycle pulses, one per instruction.
- **First fetch:** imem_req first rises in the 2nd cycle after rst_n goes high.

## Test plan
- **Reset and R instruction:** rst_n low for 2 cycles, then ADD (0x002081B3) with imem_ready tied high.
  - Expected: IDLE then F, D, E, WB. reg_we pulses in cycle 5 and pc_we with pc_sel = 0 in the same cycle.
- **LOAD with wait states:** LW 0x0040A183 with dmem_ready low for 3 cycles.
  - Expected: imm_sel = 00 and dmem_req high for 4 cycles, dmem_we = 0, then WB with wb_sel = 1. Total 8 cycles.
- **BEQ taken:** BEQ (0x00208463) with alu_zero = 1.
  - Expected: imm_sel = 10, pc_we = 1 and pc_sel = 1 in EXEC, then FETCH.
- **BNE not taken:** BNE with alu_zero = 1.
  - Expected: pc_sel = 0.
- **STORE and illegal opcode:** SW 0x0020A223, then an instruction with opcode 0x7F.
  - Expected: SW gives imm_sel = 01, dmem_we = 1, pc_we on dmem_ready. The illegal opcode goes to TRAP after DECODE; trap stays 1 and all other outputs 0 for 20 cycles; rst_n low clears it.
- **Timeout:** TIMEOUT = 4 with imem_ready held low.
  - Expected: TRAP entered after 4 FETCH cycles.
  - Repeat with ready rising in the 4th cycle: the transfer occurs and there is no trap.

Source files
------------

// File: rtl/firebird_multicycle_ctrl.sv
// Firebird RV32I multi-cycle control FSM.
// Sequences fetch/decode/exec/mem/wb and traps on bad opcodes or stalls.
module firebird_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [31:0] inst,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic [1:0] imm_sel,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       trap,
  output logic [2:0] state_dbg
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_ld;
  logic       w_is_st;
  logic       w_is_br;
  logic       w_legal;
  logic       w_br_ok;
  logic       w_taken;
  logic [1:0] w_imm;
  logic       w_wait;
  logic       w_tmo;
  logic       w_unused;

  assign w_op     = inst[6:0];
  assign w_f3     = inst[14:12];
  assign w_unused = ^{inst[31:15], inst[11:7]};

  assign w_is_r  = (w_op == 7'b0110011);
  assign w_is_i  = (w_op == 7'b0010011);
  assign w_is_ld = (w_op == 7'b0000011);
  assign w_is_st = (w_op == 7'b0100011);
  assign w_is_br = (w_op == 7'b1100011);
  assign w_legal = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br;
  assign w_br_ok = (w_f3[2:1] != 2'b01);

  always_comb begin
    w_imm = 2'b00;
    unique case (1'b1)
      w_is_st: w_imm = 2'b01;
      w_is_br: w_imm = 2'b10;
      default: w_imm = 2'b00;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = alu_zero;
      3'b001:  w_taken = !alu_zero;
      3'b100:  w_taken = alu_lt;
      3'b101:  w_taken = !alu_lt;
      3'b110:  w_taken = alu_ltu;
      3'b111:  w_taken = !alu_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // A ready arriving on the timeout cycle still completes the transfer.
  assign w_wait =
    ((r_state == S_FETCH) && !imem_ready) ||
    ((r_state == S_MEM) && !dmem_ready);
  assign w_tmo =
    (TIMEOUT != 0) && w_wait && (r_cnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready)  w_next = S_DECODE;
        else if (w_tmo)  w_next = S_TRAP;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (1'b1)
          w_is_r, w_is_i:   w_next = S_WB;
          w_is_ld, w_is_st: w_next = S_MEM;
          w_is_br: w_next = w_br_ok ? S_FETCH : S_TRAP;
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)
          w_next = w_is_ld ? S_WB : S_FETCH;
        else if (w_tmo)
          w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wait ? r_cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel   = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_DECODE: imm_sel = w_imm;
      S_EXEC: begin
        imm_sel = w_imm;
        if (w_is_r) begin
          alu_op = 2'b10;
        end else if (w_is_i) begin
          alu_src_b = 1'b1;
          alu_op    = 2'b10;
        end else if (w_is_ld || w_is_st) begin
          alu_src_b = 1'b1;
        end else if (w_is_br) begin
          alu_op = 2'b01;
          pc_we  = w_br_ok;
          pc_sel = w_br_ok & w_taken;
        end
      end
      S_MEM: begin
        imm_sel   = w_imm;
        dmem_req  = 1'b1;
        dmem_we   = w_is_st;
        alu_src_b = 1'b1;
        pc_we     = w_is_st & dmem_ready;
      end
      S_WB: begin
        imm_sel = w_imm;
        reg_we  = 1'b1;
        wb_sel  = w_is_ld;
        pc_we   = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_firebird_multicycle_ctrl.sv
// Directed bench for firebird_multicycle_ctrl (TIMEOUT = 4).
// Every cycle's full output vector is checked against hand values.
module tb_firebird_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        alu_zero, alu_lt, alu_ltu;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_we, pc_we, pc_sel;
  logic [1:0]  imm_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we, wb_sel, trap;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] ADDI = 32'h00108093;
  localparam logic [31:0] LW   = 32'h0040A183;
  localparam logic [31:0] SW   = 32'h0020A223;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] BGE  = 32'h0020D463;
  localparam logic [31:0] BLTU = 32'h0020E463;
  localparam logic [31:0] BBAD = 32'h0020A463;
  localparam logic [31:0] ILL  = 32'h0000007F;

  firebird_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,imm_sel,
  //  alu_src_b,alu_op,reg_we,wb_sel,trap,state}
  function automatic logic [16:0] ov(
    input logic [2:0] st, input logic ireq, input logic dreq,
    input logic dwe, input logic irw, input logic pcw,
    input logic pcs, input logic [1:0] imm, input logic srcb,
    input logic [1:0] op, input logic rw, input logic wbs,
    input logic trp);
    return {ireq, dreq, dwe, irw, pcw, pcs, imm,
            srcb, op, rw, wbs, trp, st};
  endfunction

  logic [16:0] w_obs;
  assign w_obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we,
                  pc_sel, imm_sel, alu_src_b, alu_op, reg_we,
                  wb_sel, trap, state_dbg};

  task automatic ck(input string tag, input logic [16:0] exp);
    @(negedge clk);
    checks++;
    assert (w_obs === exp) else begin
      errors++;
      $error("FAIL %s got=%05h exp=%05h", tag, w_obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [16:0] V_IDLE =
    17'h0;
  localparam logic [16:0] V_TRAP =
    {11'b0, 3'b001, 3'd6};

  task automatic fetch_ok(input string tag);
    imem_ready = 1'b1;
    ck(tag, ov(1, 1,0,0,1,0,0, 2'b00, 0, 2'b00, 0,0,0));
  endtask

  task automatic rst_from_trap(input string tag);
    rst_n = 1'b0;
    ck(tag, V_TRAP);
    rst_n = 1'b1;
    ck(tag, V_IDLE);
  endtask

  initial begin
    rst_n = 1'b0; inst = ADD; imem_ready = 1'b1;
    dmem_ready = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ck("idle", V_IDLE);

    fetch_ok("add_f");
    ck("add_d", ov(2, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    ck("add_e", ov(3, 0,0,0,0,0,0, 2'b00, 0, 2'b10, 0,0,0));
    ck("add_wb", ov(5, 0,0,0,0,1,0, 2'b00, 0, 2'b00, 1,0,0));

    inst = ADDI;
    fetch_ok("addi_f");
    ck("addi_d", ov(2, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    ck("addi_e", ov(3, 0,0,0,0,0,0, 2'b00, 1, 2'b10, 0,0,0));
    ck("addi_wb", ov(5, 0,0,0,0,1,0, 2'b00, 0, 2'b00, 1,0,0));

    inst = LW;
    fetch_ok("lw_f");
    ck("lw_d", ov(2, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    ck("lw_e", ov(3, 0,0,0,0,0,0, 2'b00, 1, 2'b00, 0,0,0));
    for (int i = 0; i < 3; i++)
      ck("lw_mwait", ov(4, 0,1,0,0,0,0, 2'b00, 1, 2'b00, 0,0,0));
    dmem_ready = 1'b1;
    ck("lw_m", ov(4, 0,1,0,0,0,0, 2'b00, 1, 2'b00, 0,0,0));
    dmem_ready = 1'b0;
    ck("lw_wb", ov(5, 0,0,0,0,1,0, 2'b00, 0, 2'b00, 1,1,0));

    inst = BEQ; alu_zero = 1'b1;
    fetch_ok("beq_f");
    ck("beq_d", ov(2, 0,0,0,0,0,0, 2'b10, 0, 2'b00, 0,0,0));
    ck("beq_e", ov(3, 0,0,0,0,1,1, 2'b10, 0, 2'b01, 0,0,0));

    inst = BNE;
    fetch_ok("bne_f");
    ck("bne_d", ov(2, 0,0,0,0,0,0, 2'b10, 0, 2'b00, 0,0,0));
    ck("bne_e", ov(3, 0,0,0,0,1,0, 2'b10, 0, 2'b01, 0,0,0));

    inst = BLTU; alu_zero = 1'b0; alu_ltu = 1'b1;
    fetch_ok("bltu_f");
    ck("bltu_d", ov(2, 0,0,0,0,0,0, 2'b10, 0, 2'b00, 0,0,0));
    ck("bltu_e", ov(3, 0,0,0,0,1,1, 2'b10, 0, 2'b01, 0,0,0));

    inst = BGE; alu_ltu = 1'b0; alu_lt = 1'b1;
    fetch_ok("bge_f");
    ck("bge_d", ov(2, 0,0,0,0,0,0, 2'b10, 0, 2'b00, 0,0,0));
    ck("bge_e", ov(3, 0,0,0,0,1,0, 2'b10, 0, 2'b01, 0,0,0));
    alu_lt = 1'b0;

    inst = SW;
    fetch_ok("sw_f");
    ck("sw_d", ov(2, 0,0,0,0,0,0, 2'b01, 0, 2'b00, 0,0,0));
    ck("sw_e", ov(3, 0,0,0,0,0,0, 2'b01, 1, 2'b00, 0,0,0));
    dmem_ready = 1'b1;
    ck("sw_m", ov(4, 0,1,1,0,1,0, 2'b01, 1, 2'b00, 0,0,0));
    dmem_ready = 1'b0;

    fetch_ok("swto_f");
    ck("swto_d", ov(2, 0,0,0,0,0,0, 2'b01, 0, 2'b00, 0,0,0));
    ck("swto_e", ov(3, 0,0,0,0,0,0, 2'b01, 1, 2'b00, 0,0,0));
    for (int i = 0; i < 4; i++)
      ck("swto_m", ov(4, 0,1,1,0,0,0, 2'b01, 1, 2'b00, 0,0,0));
    ck("swto_trap", V_TRAP);
    rst_from_trap("swto_rst");

    inst = ILL;
    fetch_ok("ill_f");
    ck("ill_d", ov(2, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      dmem_ready = i[1];
      ck("ill_trap", V_TRAP);
    end
    dmem_ready = 1'b0;
    rst_from_trap("ill_rst");

    inst = BBAD;
    fetch_ok("bbad_f");
    ck("bbad_d", ov(2, 0,0,0,0,0,0, 2'b10, 0, 2'b00, 0,0,0));
    ck("bbad_e", ov(3, 0,0,0,0,0,0, 2'b10, 0, 2'b01, 0,0,0));
    ck("bbad_trap", V_TRAP);
    rst_from_trap("bbad_rst");

    inst = ADD; imem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      ck("fto_f", ov(1, 1,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    ck("fto_trap", V_TRAP);
    rst_from_trap("fto_rst");

    for (int i = 0; i < 3; i++)
      ck("fok_fwait", ov(1, 1,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    fetch_ok("fok_f");
    ck("fok_d", ov(2, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 0,0,0));
    ck("fok_e", ov(3, 0,0,0,0,0,0, 2'b00, 0, 2'b10, 0,0,0));
    ck("fok_wb", ov(5, 0,0,0,0,1,0, 2'b00, 0, 2'b00, 1,0,0));
    fetch_ok("fok_f2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
